// File: rtl/router_input_port_if.sv
// Link-side bundle of one router ingress port: upstream flit/credit handshake
// plus the arbiter-facing request/grant signals.
interface router_input_port_if #(
    parameter int unsigned FLIT_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    logic [FLIT_W-1:0] flit_in;
    logic              flit_valid_in;
    logic              credit_out;
    logic [2:0]        request_bundle;
    logic [FLIT_W-1:0] flit_out;
    logic              grant_in;
    logic [OccW-1:0]   occupancy;
    logic              overflow_err;

    // Upstream link and arbiter side.
    modport master (
        output flit_in, flit_valid_in, grant_in,
        input  credit_out, request_bundle, flit_out, occupancy, overflow_err
    );

    // The input port itself.
    modport slave (
        input  flit_in, flit_valid_in, grant_in,
        output credit_out, request_bundle, flit_out, occupancy, overflow_err
    );
endinterface

// File: rtl/router_input_port.sv
// Router ingress port: credit-controlled flit FIFO plus destination-hit
// computation for the head flit, presented to the arbiter as {hit_x, hit_y, request}.
module router_input_port #(
    parameter int unsigned X_LOCAL = 0,
    parameter int unsigned Y_LOCAL = 0,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned DEPTH   = 4
) (
    input logic               clk,
    input logic               reset,
    router_input_port_if.slave port
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [FLIT_W-1:0] last_q, last_d;
    logic              credit_q;
    logic              ovf_q, ovf_d;

    logic              req;
    logic              full;
    logic              pop;
    logic              push;
    logic [FLIT_W-1:0] head;
    logic              hit_x;
    logic              hit_y;

    assign req  = (count_q != '0);
    assign full = (count_q == CntW'(DEPTH));
    // A grant on an empty port is ignored.
    assign pop  = port.grant_in & req;
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign push = port.flit_valid_in & (~full | pop);
    assign head = mem_q[rd_ptr_q];

    assign hit_x = req & (head[FLIT_W-1 -: ADDR_W] == ADDR_W'(X_LOCAL));
    assign hit_y = req & (head[FLIT_W-1-ADDR_W -: ADDR_W] == ADDR_W'(Y_LOCAL));

    // Next-state for pointers, count, held output flit and sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            last_d   = head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (port.flit_valid_in && full && !pop) ovf_d = 1'b1;
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            credit_q <= pop;
            ovf_q    <= ovf_d;
        end
    end

    // Flit storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= port.flit_in;
    end

    // When empty, flit_out shows the last popped flit (zero after reset).
    assign port.flit_out       = req ? head : last_q;
    assign port.request_bundle = {hit_x, hit_y, req};
    assign port.occupancy      = count_q;
    assign port.credit_out     = credit_q;
    assign port.overflow_err   = ovf_q;
endmodule
